// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_pkg
//  Purpose  : Shared constants and helpers for the registered ripple adder.
//             FA_MAX_WIDTH bounds the legal operand width; fa_ovf derives
//             two's-complement overflow from the carries around the MSB cell.
//  Revision : 1.0  initial release
// ============================================================================
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Signed overflow occurs exactly when the carry into the MSB cell differs
  // from the carry out of it.
  function automatic logic fa_ovf(input logic msb_cin, input logic msb_cout);
    return msb_cin ^ msb_cout;
  endfunction

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_bit
//  Purpose  : Single-bit combinational full-adder cell, one link of the
//             ripple chain.
//  Ports    : a, b  - operand bits
//             ci    - carry in from the next-lower cell
//             s     - sum bit
//             co    - carry out to the next-higher cell
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_prop;

  // Propagate term is shared between the sum and the carry expression.
  assign w_prop = a ^ b;
  assign s      = w_prop ^ ci;
  assign co     = (a & b) | (ci & w_prop);

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Purpose  : Registered WIDTH-bit ripple-carry adder. Computes
//             {cout, s} = a + b + cin through a chain of full_adder_bit cells
//             and captures the result, plus signed overflow, one cycle after
//             each cycle with in_valid high.
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset
//             in_valid  - qualifies a, b, cin this cycle
//             a, b      - unsigned operands, WIDTH bits
//             cin       - carry in
//             out_valid - s/cout/ovf hold a fresh result
//             s         - sum, (a + b + cin) mod 2^WIDTH
//             cout      - carry out of the MSB cell
//             ovf       - two's-complement overflow
//  Revision : 1.0  initial release
// ============================================================================
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Reject illegal widths while elaborating rather than building a broken chain.
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH must be in 1..%0d", FA_MAX_WIDTH);
  end

  // w_carry[i] is the carry into cell i; w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  assign w_ovf = fa_ovf(w_carry[WIDTH-1], w_carry[WIDTH]);

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d,         s_q;
  logic             cout_d,      cout_q;
  logic             ovf_d,       ovf_q;

  // Data registers only load on a valid cycle, so unqualified (possibly X)
  // operands never reach the outputs.
  always_comb begin
    out_valid_d = in_valid;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      s_d    = w_sum;
      cout_d = w_carry[WIDTH];
      ovf_d  = w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_adder
//  Purpose  : Self-checking bench for full_adder at WIDTH = 1, 8 and 16.
//             Expected results come from plain integer addition and the
//             sign-bit definition of two's-complement overflow.
//  Revision : 1.0  initial release
// ============================================================================
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v1, a1, b1, ci1;
  logic        ov1, s1, co1, of1;
  logic        v8, ci8;
  logic [7:0]  a8, b8;
  logic        ov8, co8, of8;
  logic [7:0]  s8;
  logic        v16, ci16;
  logic [15:0] a16, b16;
  logic        ov16, co16, of16;
  logic [15:0] s16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .s(s1), .cout(co1), .ovf(of1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .s(s8), .cout(co8), .ovf(of8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(ci16),
    .out_valid(ov16), .s(s16), .cout(co16), .ovf(of16)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        v;
    logic        o;
    logic        c;
    logic [63:0] s;
  } res_t;

  res_t e1, e8, e16;

  // Reference: integer sum of the operands, overflow when both operands share
  // a sign and the truncated result has the other sign.
  function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic cin);
    logic [64:0] full;
    logic [63:0] mask;
    res_t        r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + 65'(cin);
    r.v  = 1'b1;
    r.s  = full[63:0] & mask;
    r.c  = full[w];
    r.o  = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    check({tag, "/w1.valid"},  64'(ov1),  64'(e1.v));
    check({tag, "/w1.s"},      64'(s1),   e1.s);
    check({tag, "/w1.cout"},   64'(co1),  64'(e1.c));
    check({tag, "/w1.ovf"},    64'(of1),  64'(e1.o));
    check({tag, "/w8.valid"},  64'(ov8),  64'(e8.v));
    check({tag, "/w8.s"},      64'(s8),   e8.s);
    check({tag, "/w8.cout"},   64'(co8),  64'(e8.c));
    check({tag, "/w8.ovf"},    64'(of8),  64'(e8.o));
    check({tag, "/w16.valid"}, 64'(ov16), 64'(e16.v));
    check({tag, "/w16.s"},     64'(s16),  e16.s);
    check({tag, "/w16.cout"},  64'(co16), 64'(e16.c));
    check({tag, "/w16.ovf"},   64'(of16), 64'(e16.o));
  endtask

  // Drivers update the expected state as the spec describes: load on valid,
  // otherwise drop out_valid and hold the data.
  task automatic drv1(logic v, logic a, logic b, logic c);
    v1 = v; a1 = a; b1 = b; ci1 = c;
    if (v) e1 = model(1, 64'(a), 64'(b), c);
    else   e1.v = 1'b0;
  endtask

  task automatic drv8(logic v, logic [7:0] a, logic [7:0] b, logic c);
    v8 = v; a8 = a; b8 = b; ci8 = c;
    if (v) e8 = model(8, 64'(a), 64'(b), c);
    else   e8.v = 1'b0;
  endtask

  task automatic drv16(logic v, logic [15:0] a, logic [15:0] b, logic c);
    v16 = v; a16 = a; b16 = b; ci16 = c;
    if (v) e16 = model(16, 64'(a), 64'(b), c);
    else   e16.v = 1'b0;
  endtask

  // Random valid inputs with no effect on the expected state (used under reset).
  task automatic rnd_inputs();
    v1  = 1'b1; a1  = 1'($urandom); b1  = 1'($urandom); ci1  = 1'($urandom);
    v8  = 1'b1; a8  = 8'($urandom); b8  = 8'($urandom); ci8  = 1'($urandom);
    v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
  endtask

  task automatic drv_all_rand(logic v);
    drv1 (v, 1'($urandom),  1'($urandom),  1'($urandom));
    drv8 (v, 8'($urandom),  8'($urandom),  1'($urandom));
    drv16(v, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tbl_s;
  logic [7:0] tbl_c;

  initial begin
    tbl_s = 8'b1001_0110;
    tbl_c = 8'b1110_1000;

    // Reset held with live random inputs.
    rst_n = 1'b0;
    e1 = '0; e8 = '0; e16 = '0;
    rnd_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset_edge");
      #2;
      rnd_inputs();
      chk_all("reset_mid");
    end

    // First capture happens on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    drv_all_rand(1'b1);
    tick();
    chk_all("first_capture");

    // Exhaustive single-bit table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      drv1(1'b1, abc[2], abc[1], abc[0]);
      drv8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      drv16(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
      chk_all("w1_exhaustive");
      check("w1_table_s",    64'(s1),  64'(tbl_s[i]));
      check("w1_table_cout", 64'(co1), 64'(tbl_c[i]));
    end

    // Eight-bit boundary cases.
    drv8(1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    chk_all("w8_carry_prop");
    check("w8_carry_prop_s",    64'(s8),  64'h00);
    check("w8_carry_prop_cout", 64'(co8), 64'd1);
    check("w8_carry_prop_ovf",  64'(of8), 64'd0);

    drv8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    chk_all("w8_pos_ovf");
    check("w8_pos_ovf_s",    64'(s8),  64'h80);
    check("w8_pos_ovf_cout", 64'(co8), 64'd0);
    check("w8_pos_ovf_ovf",  64'(of8), 64'd1);

    drv8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk_all("w8_max");
    check("w8_max_s",    64'(s8),  64'hFF);
    check("w8_max_cout", 64'(co8), 64'd1);
    check("w8_max_ovf",  64'(of8), 64'd0);

    drv8(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    chk_all("w8_neg_ovf");
    check("w8_neg_ovf_s",    64'(s8),  64'h00);
    check("w8_neg_ovf_cout", 64'(co8), 64'd1);
    check("w8_neg_ovf_ovf",  64'(of8), 64'd1);

    // Valid gating: idle cycles with changing data must hold the last result.
    for (int i = 0; i < 3; i++) begin
      drv8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
      chk_all("w8_hold");
      check("w8_hold_valid", 64'(ov8), 64'd0);
      check("w8_hold_s",     64'(s8),  64'h00);
      check("w8_hold_cout",  64'(co8), 64'd1);
      check("w8_hold_ovf",   64'(of8), 64'd1);
    end

    drv16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    chk_all("w16_max");
    check("w16_max_s",    64'(s16),  64'hFFFF);
    check("w16_max_cout", 64'(co16), 64'd1);

    // Asynchronous reset between edges discards the in-flight add.
    drv_all_rand(1'b1);
    tick();
    chk_all("pre_async");
    drv_all_rand(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    e1 = '0; e8 = '0; e16 = '0;
    chk_all("async_reset");
    tick();
    chk_all("async_reset_held");
    @(negedge clk);
    drv_all_rand(1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset_idle");

    // Random back-to-back traffic; w16 valid every cycle, others intermittent.
    for (int n = 0; n < 10000; n++) begin
      drv1 (($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
      drv8 (($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      drv16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
      chk_all("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_full_adder
`default_nettype wire
